// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ARM-subset ALU decoder and condition logic.
//   - ALU_*   : ALUControl operation codes (3-bit core encoding)
//   - CMD_*   : Funct_cmd (instr[24:21]) encodings that the decoder recognises
//   - COND_*  : condition field (instr[31:28]) encodings
//   - FLAG_*  : bit positions of N, Z, C and V inside a 4-bit NZCV vector
//   - FLAGW_* : bit positions inside the 2-bit FlagW write-enable vector
//   - dec_t   : bundle of decoded control fields
//   - decode_op() : ALUOp/Funct_cmd/Funct_s -> dec_t
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       no_write;
    logic       illegal;
  } dec_t;

  // Address adds (alu_op = 0) decode to a plain ADD with no side effects.
  // Unknown data-processing codes suppress both the register and flag writes.
  function automatic dec_t decode_op(input logic       alu_op,
                                     input logic [3:0] cmd,
                                     input logic       s);
    dec_t d;
    d = '0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin d.alu_ctrl = ALU_ADD; d.flag_w = s ? 2'b11 : 2'b00; end
        CMD_SUB: begin d.alu_ctrl = ALU_SUB; d.flag_w = s ? 2'b11 : 2'b00; end
        CMD_AND: begin d.alu_ctrl = ALU_AND; d.flag_w = s ? 2'b10 : 2'b00; end
        CMD_ORR: begin d.alu_ctrl = ALU_ORR; d.flag_w = s ? 2'b10 : 2'b00; end
        CMD_EOR: begin d.alu_ctrl = ALU_EOR; d.flag_w = s ? 2'b10 : 2'b00; end
        CMD_MOV: begin d.alu_ctrl = ALU_MOV; d.flag_w = s ? 2'b10 : 2'b00; end
        CMD_CMP: begin d.alu_ctrl = ALU_SUB; d.flag_w = 2'b11; d.no_write = 1'b1; end
        CMD_TST: begin d.alu_ctrl = ALU_AND; d.flag_w = 2'b10; d.no_write = 1'b1; end
        default: begin d.no_write = 1'b1; d.illegal = 1'b1; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Combinational ARM condition evaluator: does condition code i_cond pass
// against the NZCV vector i_flags? Shared with the branch unit.
//   i_cond  [3:0] : condition field
//   i_flags [3:0] : NZCV flags
//   o_pass        : 1 when the condition is satisfied (1111 never passes)
// -----------------------------------------------------------------------------
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so every path drives o_pass; without it
    // an uncovered case item would infer a latch.
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_dec_cond.sv
// -----------------------------------------------------------------------------
// alu_dec_cond
// ALU decoder with architectural NZCV flag register and condition evaluation.
// Decodes ALUOp/Funct_cmd/Funct_s into ALUControl, FlagW, NoWrite and Illegal,
// optionally through one output register stage (PIPE = 1), evaluates the
// output-stage condition against the current flags (CondEx) and updates the
// flags from ALUFlags when the output-stage instruction is valid, passes its
// condition, asks for the flag group and the stage is not stalled.
//
// Parameters
//   CTRL_W : ALUControl width (>= 3); bits above 2 are always zero
//   PIPE   : 0 = decode outputs combinational, 1 = registered (1-cycle latency)
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   valid_in, stall  : input fields valid / hold output stage and block flag write
//   ALUOp, Funct_cmd, Funct_s, Cond : instruction fields
//   ALUFlags         : NZCV produced by the ALU for the output-stage instruction
//   valid_out, ALUControl, FlagW, NoWrite, Illegal : output-stage decode
//   CondEx           : output-stage condition passes (0 when not valid)
//   Flags            : architectural NZCV register
// -----------------------------------------------------------------------------
module alu_dec_cond
  import alu_pkg::*;
#(
  parameter int CTRL_W = 3,
  parameter bit PIPE   = 1'b1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              ALUOp,
  input  logic [3:0]        Funct_cmd,
  input  logic              Funct_s,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [1:0]        FlagW,
  output logic              NoWrite,
  output logic              Illegal,
  output logic              CondEx,
  output logic [3:0]        Flags
);

  dec_t       w_dec;
  dec_t       w_out;
  logic       w_valid_out;
  logic [3:0] w_cond_out;
  logic       w_cond_pass;
  logic       w_flag_en;
  logic [3:0] r_flags;

  assign w_dec = decode_op(ALUOp, Funct_cmd, Funct_s);

  if (PIPE) begin : g_pipe
    dec_t       r_dec;
    logic       r_valid;
    logic [3:0] r_cond;

    // Decoded fields of an invalid input still register; valid_out qualifies
    // them. While stalled the whole stage, including valid, holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        r_dec   <= '0;
        r_valid <= 1'b0;
        r_cond  <= '0;
      end else if (!stall) begin
        r_dec   <= w_dec;
        r_valid <= valid_in;
        r_cond  <= Cond;
      end
    end

    assign w_out       = r_dec;
    assign w_valid_out = r_valid;
    assign w_cond_out  = r_cond;
  end else begin : g_comb
    assign w_out       = w_dec;
    assign w_valid_out = valid_in;
    assign w_cond_out  = Cond;
  end

  cond_check u_cond_check (
    .i_cond  (w_cond_out),
    .i_flags (r_flags),
    .o_pass  (w_cond_pass)
  );

  // The previous instruction's flag update lands on the edge before the next
  // instruction reaches the output stage, so CondEx needs no bypass path.
  assign w_flag_en = w_valid_out & w_cond_pass & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_flag_en) begin
      if (w_out.flag_w[FLAGW_NZ]) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (w_out.flag_w[FLAGW_CV]) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign valid_out  = w_valid_out;
  assign ALUControl = CTRL_W'(w_out.alu_ctrl);
  assign FlagW      = w_out.flag_w;
  assign NoWrite    = w_out.no_write;
  assign Illegal    = w_out.illegal;
  assign CondEx     = w_cond_pass & w_valid_out;
  assign Flags      = r_flags;

endmodule

// File: tb/tb_alu_dec_cond.sv
// -----------------------------------------------------------------------------
// tb_alu_dec_cond
// Self-checking bench for alu_dec_cond (PIPE = 1, CTRL_W = 3). Directed
// scenarios check against hand-derived constants; the sweep and random phases
// check against a reference model of the output stage and the flag register.
// -----------------------------------------------------------------------------
module tb_alu_dec_cond;

  logic       clk = 1'b0;
  logic       reset, valid_in, stall, alu_op, funct_s;
  logic [3:0] funct_cmd, cond, alu_flags;
  logic       valid_out, no_write, illegal, cond_ex;
  logic [2:0] alu_control;
  logic [1:0] flag_w;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  // Reference model state: contents of the output stage and the flags.
  logic       m_valid;
  logic [2:0] m_ctrl;
  logic [1:0] m_fw;
  logic       m_nw, m_ill;
  logic [3:0] m_cond, m_flags;

  alu_dec_cond #(.CTRL_W(3), .PIPE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .stall      (stall),
    .ALUOp      (alu_op),
    .Funct_cmd  (funct_cmd),
    .Funct_s    (funct_s),
    .Cond       (cond),
    .ALUFlags   (alu_flags),
    .valid_out  (valid_out),
    .ALUControl (alu_control),
    .FlagW      (flag_w),
    .NoWrite    (no_write),
    .Illegal    (illegal),
    .CondEx     (cond_ex),
    .Flags      (flags)
  );

  always #5 clk = ~clk;

  // Condition as "base test, inverted when cond[0] is set"; 1110 -> 1, 1111 -> 0.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Returns {ctrl[2:0], flagw[1:0], nowrite, illegal} from the opcode table.
  function automatic logic [6:0] ref_dec(input logic op, input logic [3:0] cmd, input logic s);
    logic [1:0] arith, logic_fw;
    arith    = s ? 2'b11 : 2'b00;
    logic_fw = s ? 2'b10 : 2'b00;
    if (!op) return 7'b000_00_0_0;
    case (cmd)
      4'b0100: return {3'd0, arith,    2'b00};
      4'b0010: return {3'd1, arith,    2'b00};
      4'b0000: return {3'd2, logic_fw, 2'b00};
      4'b1100: return {3'd3, logic_fw, 2'b00};
      4'b0001: return {3'd4, logic_fw, 2'b00};
      4'b1101: return {3'd5, logic_fw, 2'b00};
      4'b1010: return {3'd1, 2'b11,    2'b10};
      4'b1000: return {3'd2, 2'b10,    2'b10};
      default: return {3'd0, 2'b00,    2'b11};
    endcase
  endfunction

  // Advance one clock: update the model from the currently driven inputs,
  // then let the DUT take the edge and sample 1 time unit later.
  task automatic tick();
    logic [6:0] d;
    if (!reset && !stall && m_valid && ref_cond(m_cond, m_flags)) begin
      if (m_fw[1]) m_flags[3:2] = alu_flags[3:2];
      if (m_fw[0]) m_flags[1:0] = alu_flags[1:0];
    end
    if (reset) begin
      m_flags = 4'b0; m_valid = 1'b0; m_ctrl = 3'b0; m_fw = 2'b0;
      m_nw = 1'b0; m_ill = 1'b0; m_cond = 4'b0;
    end else if (!stall) begin
      d = ref_dec(alu_op, funct_cmd, funct_s);
      m_valid = valid_in;
      {m_ctrl, m_fw, m_nw, m_ill} = d;
      m_cond = cond;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic op, input logic [3:0] cmd,
                       input logic s, input logic [3:0] c);
    valid_in = v; alu_op = op; funct_cmd = cmd; funct_s = s; cond = c;
  endtask

  // Load the flag register with an ADDS/AL, leaving the output stage empty.
  task automatic set_flags(input logic [3:0] f);
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b1110);
    tick();
    alu_flags = f;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; alu_flags = 4'b1111;
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b1110);
    tick(); tick();
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if ({alu_control, flag_w, no_write, illegal} !== 7'b0) begin errors++;
      $display("FAIL reset_decode got %b want 0000000", {alu_control, flag_w, no_write, illegal}); end
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL reset_condex got %b want 0", cond_ex); end
    reset = 1'b0;
  endtask

  task automatic test_adds();
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b1110);
    tick();
    checks++; if (alu_control !== 3'b000 || flag_w !== 2'b11 || valid_out !== 1'b1 || cond_ex !== 1'b1) begin errors++;
      $display("FAIL adds_decode got ctrl=%b fw=%b v=%b cx=%b want 000 11 1 1", alu_control, flag_w, valid_out, cond_ex); end
    alu_flags = 4'b0110;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1110);
    tick();
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL adds_flags got %b want 0110", flags); end
  endtask

  task automatic test_flag_gating();
    set_flags(4'b0100);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL gate_setup got %b want 0100", flags); end
    drive(1'b1, 1'b1, 4'b0010, 1'b1, 4'b0001);   // SUBS NE
    tick();
    alu_flags = 4'b1000;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1110);
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL gate_ne_condex got %b want 0", cond_ex); end
    tick();
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL gate_ne_flags got %b want 0100", flags); end
    drive(1'b1, 1'b1, 4'b0010, 1'b1, 4'b0000);   // SUBS EQ
    tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1110);
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL gate_eq_condex got %b want 1", cond_ex); end
    tick();
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL gate_eq_flags got %b want 1000", flags); end
  endtask

  task automatic test_cmp_tst();
    drive(1'b1, 1'b1, 4'b1010, 1'b0, 4'b1111);
    tick();
    checks++; if ({alu_control, flag_w, no_write, illegal} !== {3'b001, 2'b11, 1'b1, 1'b0}) begin errors++;
      $display("FAIL cmp_decode got %b want 0011110", {alu_control, flag_w, no_write, illegal}); end
    drive(1'b1, 1'b1, 4'b1000, 1'b0, 4'b1111);
    tick();
    checks++; if ({alu_control, flag_w, no_write, illegal} !== {3'b010, 2'b10, 1'b1, 1'b0}) begin errors++;
      $display("FAIL tst_decode got %b want 0101010", {alu_control, flag_w, no_write, illegal}); end
  endtask

  task automatic test_illegal_addr();
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
    tick();
    checks++; if ({alu_control, flag_w, no_write, illegal} !== {3'b000, 2'b00, 1'b1, 1'b1}) begin errors++;
      $display("FAIL illegal_decode got %b want 0000011", {alu_control, flag_w, no_write, illegal}); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'b1111);
      tick();
      checks++; if ({alu_control, flag_w, no_write, illegal} !== 7'b0) begin errors++;
        $display("FAIL addr_decode got %b want 0000000", {alu_control, flag_w, no_write, illegal}); end
    end
  endtask

  task automatic test_stall();
    set_flags(4'b0011);
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 4'b1110);   // ANDS AL
    tick();
    alu_flags = 4'b1000; stall = 1'b1;
    drive(1'b1, 1'b1, 4'b1100, 1'b0, 4'b1111);   // ORR waiting at the input
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (flags !== 4'b0011 || alu_control !== 3'b010 || flag_w !== 2'b10 || valid_out !== 1'b1) begin errors++;
        $display("FAIL stall_hold got flags=%b ctrl=%b fw=%b v=%b want 0011 010 10 1", flags, alu_control, flag_w, valid_out); end
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1110);
    tick();
    checks++; if (flags !== 4'b1011) begin errors++; $display("FAIL stall_release got %b want 1011", flags); end
  endtask

  task automatic test_cond_sweep();
    logic [3:0] fv [5] = '{4'b0000, 4'b0100, 4'b1001, 4'b0010, 4'b1101};
    for (int i = 0; i < 5; i++) begin
      set_flags(fv[i]);
      checks++; if (flags !== fv[i]) begin errors++; $display("FAIL sweep_setup got %b want %b", flags, fv[i]); end
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 1'b0, 4'b0000, 1'b0, 4'(c));
        tick();
        checks++; if (cond_ex !== ref_cond(4'(c), fv[i])) begin errors++;
          $display("FAIL sweep cond=%b flags=%b got %b want %b", 4'(c), fv[i], cond_ex, ref_cond(4'(c), fv[i])); end
      end
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 4'b1110);  // AL but invalid
      tick();
      checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL sweep_invalid got %b want 0", cond_ex); end
    end
  endtask

  task automatic test_reset_pending();
    set_flags(4'b0101);
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b1110);
    tick();
    alu_flags = 4'b1111; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (flags !== 4'b0000 || valid_out !== 1'b0) begin errors++;
      $display("FAIL reset_pending got flags=%b v=%b want 0000 0", flags, valid_out); end
  endtask

  task automatic test_random();
    logic [3:0] legal [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010, 4'b1000};
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      valid_in  = ($urandom_range(0, 3) != 0);
      alu_op    = ($urandom_range(0, 4) != 0);
      funct_cmd = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 7)] : 4'($urandom_range(0, 15));
      funct_s   = 1'($urandom_range(0, 1));
      cond      = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      alu_flags = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (valid_out !== m_valid || alu_control !== m_ctrl || flag_w !== m_fw || no_write !== m_nw ||
          illegal !== m_ill || flags !== m_flags || cond_ex !== (m_valid && ref_cond(m_cond, m_flags))) begin
        errors++;
        $display("FAIL random it=%0d got v=%b ctrl=%b fw=%b nw=%b ill=%b fl=%b cx=%b want v=%b ctrl=%b fw=%b nw=%b ill=%b fl=%b cx=%b",
                 k, valid_out, alu_control, flag_w, no_write, illegal, flags, cond_ex,
                 m_valid, m_ctrl, m_fw, m_nw, m_ill, m_flags, m_valid && ref_cond(m_cond, m_flags));
      end
    end
    reset = 1'b0; stall = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0; m_ctrl = 3'b0; m_fw = 2'b0; m_nw = 1'b0; m_ill = 1'b0;
    m_cond = 4'b0; m_flags = 4'b0;
    test_reset();
    test_adds();
    test_flag_gating();
    test_cmp_tst();
    test_illegal_addr();
    test_stall();
    test_cond_sweep();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
